// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } fetch_state_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES - 1));
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Redirect, instruction-memory and decode channels of the fetch stage.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_buf.sv
// Holding register for the {pc, instr} pair presented to decode.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding instruction memory reads, redirect handling
// with discard of stale responses, and a one-entry output buffer to decode.
//
// state | meaning
// IDLE  | just out of reset, nothing issued
// REQ   | read request to fetch_pc presented
// WAIT  | request accepted, response pending (drop=1: discard it)
// FULL  | {if_pc, if_instr} held for decode
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.master bus
);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic            drop;
    logic            buf_load;

    assign buf_load = (state == WAIT) && bus.imem_rsp_valid && !drop && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= align_word(RESET_PC);
            drop     <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= align_word(bus.redirect_pc);
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // An accepted stale request still owes us a response.
                    if (bus.imem_req_ready) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                FULL:    state <= REQ;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (bus.imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.if_ready) begin
                        fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.if_valid       = (state == FULL);

    fetch_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .pc_in    (fetch_pc),
        .instr_in (bus.imem_rsp_data),
        .pc       (bus.if_pc),
        .instr    (bus.if_instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model plus queues of expected
// request addresses and decode pairs.
`timescale 1ns/1ps
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int cyc      = 0;
    int lat      = 1;
    int rsp_cnt  = 0;
    logic [31:0] pend_addr = '0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_instr[$];
    int          out_t[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h13A5_C0DE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pair(input logic [31:0] pc);
        exp_pc.push_back(pc);
        exp_instr.push_back(mem_word(pc));
    endtask

    task automatic wait_acc(input string tag);
        int start = n_acc;
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (n_acc > start) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_out(input string tag);
        int start = n_out;
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (n_out > start) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_ifv(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (bus.if_valid === 1'b1) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    // Memory model and output monitor, all sampled on the falling edge.
    initial begin : mem_model
        logic [31:0] e;
        logic [31:0] ep;
        logic [31:0] ei;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.imem_rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(pend_addr);
                end
            end
            if (!rst && bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
                e = (exp_req.size() > 0) ? exp_req.pop_front() : 32'hBAD0_BAD0;
                chk("req_addr", bus.imem_req_addr, e);
                pend_addr = bus.imem_req_addr;
                rsp_cnt   = lat;
                n_acc++;
            end
            if (!rst && bus.if_valid === 1'b1 && bus.if_ready) begin
                ep = (exp_pc.size() > 0)    ? exp_pc.pop_front()    : 32'hBAD1_BAD1;
                ei = (exp_instr.size() > 0) ? exp_instr.pop_front() : 32'hBAD2_BAD2;
                chk("out_pc", bus.if_pc, ep);
                chk("out_instr", bus.if_instr, ei);
                out_t.push_back(cyc);
                n_out++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        lat = 1;

        // Reset and straight-line fetch
        step(2);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        for (int a = 0; a < 16; a += 4) begin
            exp_req.push_back(32'(a));
            push_pair(32'(a));
        end
        rst = 1'b0;
        chk("idle_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step(1);
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, RESET_PC);
        for (int k = 0; k < 3; k++) wait_out("p1_out_seen");
        bus.if_ready = 1'b0;
        chk("p1_spacing_a", 32'(out_t[1] - out_t[0]), 32'd3);
        chk("p1_spacing_b", 32'(out_t[2] - out_t[1]), 32'd3);

        // Decode backpressure on 0xC
        wait_ifv("p2_full_seen");
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bp_if_valid", 32'(bus.if_valid), 32'd1);
            chk("bp_if_pc", bus.if_pc, 32'h0000_000C);
            chk("bp_if_instr", bus.if_instr, mem_word(32'h0000_000C));
            chk("bp_no_req", 32'(bus.imem_req_valid), 32'd0);
        end

        // Redirect while WAIT on 0x10, response 3 cycles after acceptance
        exp_req.push_back(32'h0000_0010);
        lat = 3;
        bus.if_ready = 1'b1;
        wait_acc("p3_acc_seen");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.if_ready       = 1'b0;
        exp_req.push_back(32'h0000_0200);
        push_pair(32'h0000_0200);
        step(1);
        bus.redirect_valid = 1'b0;
        lat = 1;
        wait_ifv("p3_full_seen");
        chk("p3_if_pc", bus.if_pc, 32'h0000_0200);
        chk("p3_if_instr", bus.if_instr, mem_word(32'h0000_0200));

        // Redirect coincident with the response for 0x204
        exp_req.push_back(32'h0000_0204);
        bus.if_ready = 1'b1;
        wait_acc("p4a_acc_seen");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0403;
        bus.if_ready       = 1'b0;
        exp_req.push_back(32'h0000_0400);
        push_pair(32'h0000_0400);
        step(1);
        bus.redirect_valid = 1'b0;
        wait_ifv("p4a_full_seen");
        chk("p4a_if_pc", bus.if_pc, 32'h0000_0400);
        chk("p4a_if_instr", bus.if_instr, mem_word(32'h0000_0400));

        // Redirect together with if_ready in FULL: no +4
        exp_req.push_back(32'h0000_0400);
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0403;
        step(1);
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        wait_ifv("p4b_full_seen");
        chk("p4b_if_pc", bus.if_pc, 32'h0000_0400);

        // Redirect to the last word, then wrap to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        exp_req.push_back(32'hFFFF_FFFC);
        push_pair(32'hFFFF_FFFC);
        step(1);
        bus.redirect_valid = 1'b0;
        wait_ifv("p5_top_full_seen");
        chk("p5_top_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        push_pair(32'h0000_0000);
        bus.if_ready = 1'b1;
        wait_acc("p5_wrap_acc_seen");
        bus.if_ready = 1'b0;
        wait_ifv("p5_wrap_full_seen");
        chk("p5_wrap_if_pc", bus.if_pc, 32'h0000_0000);

        // Reset while WAIT on 0x4; its response arrives after reset
        exp_req.push_back(32'h0000_0004);
        lat = 4;
        bus.if_ready = 1'b1;
        wait_acc("p6_acc_seen");
        rst = 1'b1;
        bus.if_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        step(1);
        rst = 1'b0;
        chk("mid_rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step(1);
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
        step(3);
        chk("late_rsp_if_valid", 32'(bus.if_valid), 32'd0);
        chk("late_rsp_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("late_rsp_req_addr", bus.imem_req_addr, RESET_PC);
        exp_req.push_back(RESET_PC);
        exp_req.push_back(RESET_PC + 32'd4);
        push_pair(RESET_PC);
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready = 1'b1;
        wait_out("p6_out_seen");
        bus.if_ready = 1'b0;
        step(6);

        chk("exp_req_drained", 32'(exp_req.size()), 32'd0);
        chk("exp_pair_drained", 32'(exp_pc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
